adc5g_spi_responder: RTL
========================

# adc5g_spi_responder

Responder end of the three-wire configuration link driven by the DMUX controller: behavioural-grade synthesizable SPI slave that receives the 24-bit {addr[7:0], data[15:0]} frames destined for the e2V 5 Gsps ADC. It maintains the shadow register file, pulses a write strobe per committed frame and, optionally, returns register contents on read frames. It sits on the test/emulation side of the ROACH board (ADC emulator and loopback bench), clocked by the fabric clock that oversamples the SPI lines.

## Interface
- NREGS, 16: implemented registers, addresses 0..NREGS-1 (power of two, 2..128)
- clk  in  1  fabric clock; oversamples SPI by ≥8×
- rst  in  1  reset, asynchronous and active-high; one clock; reset is asynchronous and active-high
- spi_clk_i  in  1  SCLK, idles low, master launches data on falling edge
- spi_mode_i  in  1  frame enable, active-low (low for exactly 24 SCLK periods)
- spi_rst_n_i  in  1  SPI reset, active-low
- spi_data_i  in  1  MOSI, MSB first
- spi_data_o  out  1  MISO, reset 0
- cfg_regs_o  out  16*NREGS  flat register file, reg k at [16k+15:16k], reset = package defaults
- wr_stb_o  out  1  one-cycle pulse per committed write, reset 0
- wr_addr_o  out  7  address of last commit, reset 0
- wr_data_o  out  16  data of last commit, reset 0
- frame_err_o  out  1  one-cycle pulse per discarded frame, reset 0
- busy_o  out  1  high while state ≠ IDLE, reset 0

## Operation
- All four SPI inputs pass through 2-FF synchronizers; edges detected on synced values.
- Bit captured on synced SCLK rising edge into 24-bit shift register (left shift, LSB in); counter bit_cnt 0..24, saturating at 25.
- addr[7]=1 write, 0 read; addr[6:0] register index.
- States: IDLE → ADDR on synced spi_mode falling edge (bit_cnt←0). ADDR → DATA when bit_cnt reaches 8. DATA → DONE when bit_cnt reaches 24. DONE → ERR on any further rising edge. ADDR/DATA/DONE/ERR → IDLE on synced spi_mode rising edge.
- Commit on mode rise from DONE: write with addr[6:0] < NREGS → update register, wr_addr_o/wr_data_o, pulse wr_stb_o. Write with addr[6:0] ≥ NREGS → frame_err_o, no update. Read → no register change, no pulse.
- Mode rise from ADDR, DATA or ERR (≠24 bits) → frame_err_o, no update.
- Synced spi_rst_n low: registers to defaults, state IDLE, shift register and bit_cnt cleared, no error pulse; mode falls ignored while low.

## Timing
- SCLK high and low phases each ≥4 clk; mode setup to first SCLK rise ≥4 clk.
- Input-to-sampled latency 3 clk (2 sync + 1 edge detect).
- Commit latency: wr_stb_o, cfg_regs_o, wr_addr_o/data_o update 1 clk after synced mode rise detection (4 clk after raw pin).
- Simultaneous SCLK rise and mode rise in same cycle: mode rise wins, bit not counted.
- Reset mid-frame (rst or spi_rst_n): frame dropped silently.
- busy_o asserts the cycle after mode fall detection, deasserts with commit.

## Configuration
- ADC5G_SPI_READBACK_EN defined: on read frame, after 8th address bit, MISO shifts register[addr] MSB first, next bit on each synced SCLK falling edge, 16 bits; unimplemented address returns 0x0000; spi_data_o returns 0 at mode rise.
- Undefined: spi_data_o tied 0; read frames accepted and ignored.

## Structure
- Package adc5g_spi_pkg: FRAME_W=24, ADDR_W=8, DATA_W=16, state enumeration, WRITE_BIT=7, default register table (reg 0x01 = 16'h0308, all others 16'h0000).
- Sub-module adc5g_sync2: 2-FF synchronizer with async active-high reset, reset value parameter (1 for spi_rst_n, spi_mode; 0 otherwise).

## Test plan
- After rst: cfg_regs_o reg1=0x0308, others 0; spi_data_o=0, busy_o=0.
- Write frame 24'h810348 -> wr_stb_o one pulse, wr_addr_o=0x01, wr_data_o=0x0348, reg1=0x0348.
- Frame aborted after 13 bits, then 25-bit frame -> two frame_err_o pulses, registers unchanged.
- Write 24'h8A1234 with NREGS=8 -> frame_err_o, no wr_stb_o.
- With ADC5G_SPI_READBACK_EN, read frame 24'h010000 after reg1=0x0348 -> MISO carries 0x0348 MSB first on bits 9..24.
- spi_rst_n low mid write of reg3 -> frame dropped, reg1 back to 0x0308, no error pulse.

Source files
------------

// File: rtl/adc5g_spi_pkg.sv
// Shared constants, FSM encoding and power-on register table for the ADC5G SPI responder.
package adc5g_spi_pkg;

  localparam int unsigned FRAME_W   = 24;
  localparam int unsigned ADDR_W    = 8;
  localparam int unsigned DATA_W    = 16;
  localparam int unsigned IDX_W_MAX = 7;
  localparam int unsigned WRITE_BIT = 7;
  localparam int unsigned CNT_W     = 5;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_DATA = 3'd2,
    ST_DONE = 3'd3,
    ST_ERR  = 3'd4
  } state_e;

  function automatic logic [DATA_W-1:0] reg_default(input int unsigned k);
    return (k == 1) ? 16'h0308 : 16'h0000;
  endfunction

endpackage

// File: rtl/adc5g_spi_responder_if.sv
// Three-wire configuration link plus MISO between the DMUX controller and the responder.
interface adc5g_spi_responder_if;
  logic spi_clk_i;
  logic spi_mode_i;
  logic spi_rst_n_i;
  logic spi_data_i;
  logic spi_data_o;

  modport master (output spi_clk_i, spi_mode_i, spi_rst_n_i, spi_data_i, input spi_data_o);
  modport slave  (input spi_clk_i, spi_mode_i, spi_rst_n_i, spi_data_i, output spi_data_o);
endinterface

// File: rtl/adc5g_sync2.sv
// Two-flop synchronizer with asynchronous active-high reset to a chosen idle level.
module adc5g_sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/adc5g_spi_responder.sv
// SPI slave holding the ADC5G shadow register file; commits 24-bit {addr,data} frames on mode rise.
// Define ADC5G_SPI_READBACK_EN to return register contents on MISO for read frames.
module adc5g_spi_responder
  import adc5g_spi_pkg::*;
#(
  parameter int unsigned NREGS = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  adc5g_spi_responder_if.slave      spi,
  output logic [16*NREGS-1:0]       cfg_regs_o,
  output logic                      wr_stb_o,
  output logic [IDX_W_MAX-1:0]      wr_addr_o,
  output logic [DATA_W-1:0]         wr_data_o,
  output logic                      frame_err_o,
  output logic                      busy_o
);

  localparam int unsigned IDX_W = (NREGS > 1) ? $clog2(NREGS) : 1;

  logic sclk_s, mode_s, srst_n_s, mosi_s;

  adc5g_sync2 #(.RST_VAL(1'b0)) u_sync_sclk  (.clk(clk), .rst(rst), .d_i(spi.spi_clk_i),   .q_o(sclk_s));
  adc5g_sync2 #(.RST_VAL(1'b1)) u_sync_mode  (.clk(clk), .rst(rst), .d_i(spi.spi_mode_i),  .q_o(mode_s));
  adc5g_sync2 #(.RST_VAL(1'b1)) u_sync_srst  (.clk(clk), .rst(rst), .d_i(spi.spi_rst_n_i), .q_o(srst_n_s));
  adc5g_sync2 #(.RST_VAL(1'b0)) u_sync_mosi  (.clk(clk), .rst(rst), .d_i(spi.spi_data_i),  .q_o(mosi_s));

  state_e                       state_q, state_d;
  logic                         sclk_prev_q, mode_prev_q;
  logic [FRAME_W-1:0]           sr_q, sr_d, sr_shift;
  logic [CNT_W-1:0]             cnt_q, cnt_d, cnt_inc;
  logic [NREGS-1:0][DATA_W-1:0] regs_q, regs_d;
  logic                         wr_stb_q, wr_stb_d;
  logic                         err_q, err_d;
  logic [IDX_W_MAX-1:0]         wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]            wr_data_q, wr_data_d;
  logic                         busy_q, busy_d;
  logic                         sclk_rise, mode_rise, mode_fall;
  logic [IDX_W_MAX-1:0]         frm_idx;
  logic                         frm_idx_ok;

  assign sclk_rise  = sclk_s & ~sclk_prev_q;
  assign mode_rise  = mode_s & ~mode_prev_q;
  assign mode_fall  = ~mode_s & mode_prev_q;
  assign sr_shift   = {sr_q[FRAME_W-2:0], mosi_s};
  assign cnt_inc    = (cnt_q == CNT_W'(25)) ? CNT_W'(25) : cnt_q + CNT_W'(1);
  assign frm_idx    = sr_q[DATA_W +: IDX_W_MAX];
  assign frm_idx_ok = 32'(frm_idx) < NREGS;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Mode rise takes priority over a coincident SCLK rise.
  always_comb begin
    state_d = state_q;
    if (!srst_n_s) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (mode_fall) state_d = ST_ADDR;
        ST_ADDR: if (mode_rise) state_d = ST_IDLE;
                 else if (sclk_rise && cnt_inc == CNT_W'(8)) state_d = ST_DATA;
        ST_DATA: if (mode_rise) state_d = ST_IDLE;
                 else if (sclk_rise && cnt_inc == CNT_W'(24)) state_d = ST_DONE;
        ST_DONE: if (mode_rise) state_d = ST_IDLE;
                 else if (sclk_rise) state_d = ST_ERR;
        ST_ERR:  if (mode_rise) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    regs_d    = regs_q;
    wr_stb_d  = 1'b0;
    err_d     = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    busy_d    = (state_d != ST_IDLE);
    if (!srst_n_s) begin
      sr_d  = '0;
      cnt_d = '0;
      for (int unsigned k = 0; k < NREGS; k++) regs_d[k] = reg_default(k);
    end else if (state_q == ST_IDLE) begin
      if (mode_fall) begin
        sr_d  = '0;
        cnt_d = '0;
      end
    end else if (mode_rise) begin
      // Only a full 24-bit write to an implemented register commits.
      if (state_q == ST_DONE) begin
        if (sr_q[DATA_W + WRITE_BIT]) begin
          if (frm_idx_ok) begin
            regs_d[frm_idx[IDX_W-1:0]] = sr_q[DATA_W-1:0];
            wr_addr_d = frm_idx;
            wr_data_d = sr_q[DATA_W-1:0];
            wr_stb_d  = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end else begin
        err_d = 1'b1;
      end
    end else if (sclk_rise) begin
      sr_d  = sr_shift;
      cnt_d = cnt_inc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_prev_q <= 1'b0;
      mode_prev_q <= 1'b1;
      sr_q        <= '0;
      cnt_q       <= '0;
      for (int unsigned k = 0; k < NREGS; k++) regs_q[k] <= reg_default(k);
      wr_stb_q    <= 1'b0;
      err_q       <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      busy_q      <= 1'b0;
    end else begin
      sclk_prev_q <= sclk_s;
      mode_prev_q <= mode_s;
      sr_q        <= sr_d;
      cnt_q       <= cnt_d;
      regs_q      <= regs_d;
      wr_stb_q    <= wr_stb_d;
      err_q       <= err_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      busy_q      <= busy_d;
    end
  end

`ifdef ADC5G_SPI_READBACK_EN
  logic                 sclk_fall;
  logic                 miso_q, miso_d;
  logic [DATA_W-1:0]    rd_sr_q, rd_sr_d, rd_word;
  logic [IDX_W_MAX-1:0] rd_idx;

  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign rd_idx    = sr_shift[IDX_W_MAX-1:0];
  assign rd_word   = (32'(rd_idx) < NREGS) ? regs_q[rd_idx[IDX_W-1:0]] : '0;

  // Word is latched on the 8th address bit and shifted out on the following 16 falls.
  always_comb begin
    miso_d  = miso_q;
    rd_sr_d = rd_sr_q;
    if (!srst_n_s) begin
      miso_d  = 1'b0;
      rd_sr_d = '0;
    end else if (state_q != ST_IDLE) begin
      if (mode_rise) begin
        miso_d  = 1'b0;
        rd_sr_d = '0;
      end else if (sclk_rise) begin
        if (state_q == ST_ADDR && cnt_inc == CNT_W'(8))
          rd_sr_d = sr_shift[WRITE_BIT] ? '0 : rd_word;
      end else if (sclk_fall && state_q == ST_DATA) begin
        miso_d  = rd_sr_q[DATA_W-1];
        rd_sr_d = {rd_sr_q[DATA_W-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      miso_q  <= 1'b0;
      rd_sr_q <= '0;
    end else begin
      miso_q  <= miso_d;
      rd_sr_q <= rd_sr_d;
    end
  end

  assign spi.spi_data_o = miso_q;
`else
  assign spi.spi_data_o = 1'b0;
`endif

  assign cfg_regs_o  = regs_q;
  assign wr_stb_o    = wr_stb_q;
  assign wr_addr_o   = wr_addr_q;
  assign wr_data_o   = wr_data_q;
  assign frame_err_o = err_q;
  assign busy_o      = busy_q;

endmodule
